// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared BCD types and helpers for the score bank
package score_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;

    // Widest score the helpers handle; callers slice down to their own width.
    localparam int BCD_MAX_DIGITS = 8;
    typedef logic [BCD_MAX_DIGITS*4-1:0] bcd_wide_t;

    // All-9s pattern for the low 'digits' digits, zero above.
    function automatic bcd_wide_t bcd_all_nines(input int digits);
        bcd_wide_t v;
        v = '0;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            if (i < digits) begin
                v[i*4 +: 4] = BCD_NINE;
            end
        end
        return v;
    endfunction

    // Valid BCD (every digit 0..9) orders exactly like plain binary, so a
    // straight magnitude compare is enough.
    function automatic logic bcd_gt(input bcd_wide_t a, input bcd_wide_t b);
        return a > b;
    endfunction

endpackage

// File: rtl/bcd_addsub.sv
// rtl/bcd_addsub.sv - ripple BCD add/subtract of a single-digit operand
module bcd_addsub #(
    parameter int DIGITS = 3
) (
    input  logic [DIGITS*4-1:0] i_value,
    input  logic [3:0]          i_operand,
    input  logic                i_sub,
    output logic [DIGITS*4-1:0] o_result,
    output logic                o_carry_out,
    output logic                o_borrow_out
);

    logic [4:0] w_acc;
    logic [3:0] w_c;

    // Digit 0 takes the operand, higher digits take the 0/1 carry or borrow.
    always_comb begin
        o_result = '0;
        w_acc    = '0;
        w_c      = i_operand;
        for (int d = 0; d < DIGITS; d++) begin
            if (!i_sub) begin
                w_acc = {1'b0, i_value[d*4 +: 4]} + {1'b0, w_c};
                if (w_acc > 5'd9) begin
                    o_result[d*4 +: 4] = w_acc[3:0] + 4'd6;
                    w_c                = 4'd1;
                end else begin
                    o_result[d*4 +: 4] = w_acc[3:0];
                    w_c                = 4'd0;
                end
            end else begin
                w_acc = {1'b0, i_value[d*4 +: 4]} - {1'b0, w_c};
                if (w_acc[4]) begin
                    o_result[d*4 +: 4] = w_acc[3:0] - 4'd6;
                    w_c                = 4'd1;
                end else begin
                    o_result[d*4 +: 4] = w_acc[3:0];
                    w_c                = 4'd0;
                end
            end
        end
        o_carry_out  = !i_sub && (w_c != 4'd0);
        o_borrow_out = i_sub && (w_c != 4'd0);
    end

endmodule

// File: rtl/score_bank.sv
// rtl/score_bank.sv - multi-player BCD score keeper with combo and high-score tracker
module score_bank
    import score_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int DIGITS       = 3,
    parameter int COMBO_STEP   = 4,
    parameter int MAX_MULT     = 4,
    parameter int MISS_PENALTY = 2,
    localparam int LW          = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          clear,
    input  logic [NUM_PLAYERS-1:0]        hit_pulse,
    input  logic [NUM_PLAYERS-1:0]        miss_pulse,
    output logic [NUM_PLAYERS*DIGITS*4-1:0] score,
    output logic [NUM_PLAYERS*4-1:0]      mult,
    output logic [NUM_PLAYERS-1:0]        saturated,
    output logic [DIGITS*4-1:0]           high_score,
    output logic [LW-1:0]                 leader,
    output logic                          new_high
);

    localparam int SW  = DIGITS * 4;
    localparam int STW = $clog2(COMBO_STEP + 1);

    localparam bcd_wide_t       ALL_NINES_W = bcd_all_nines(DIGITS);
    localparam logic [SW-1:0]   ALL_NINES   = ALL_NINES_W[SW-1:0];
    localparam logic [3:0]      PENALTY     = 4'(MISS_PENALTY);
    localparam logic [3:0]      MAX_M       = 4'(MAX_MULT);
    localparam logic [STW-1:0]  STEP        = STW'(COMBO_STEP);

    genvar p;
    generate
        for (p = 0; p < NUM_PLAYERS; p++) begin : g_player
            logic [SW-1:0]  r_score;
            logic [3:0]     r_mult;
            logic [STW-1:0] r_streak;
            logic [SW-1:0]  w_sum;
            logic           w_carry;
            logic           w_borrow;
            logic [3:0]     w_operand;
            logic [STW-1:0] w_streak_inc;

            // A miss wins over a hit, so the adder subtracts whenever miss is set.
            assign w_operand    = miss_pulse[p] ? PENALTY : r_mult;
            assign w_streak_inc = r_streak + STW'(1);

            bcd_addsub #(.DIGITS(DIGITS)) u_addsub (
                .i_value      (r_score),
                .i_operand    (w_operand),
                .i_sub        (miss_pulse[p]),
                .o_result     (w_sum),
                .o_carry_out  (w_carry),
                .o_borrow_out (w_borrow)
            );

            // Per-player score, streak and multiplier: clear > hold > miss > hit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_score  <= '0;
                    r_mult   <= 4'd1;
                    r_streak <= '0;
                end else if (clear) begin
                    r_score  <= '0;
                    r_mult   <= 4'd1;
                    r_streak <= '0;
                end else if (enable) begin
                    if (miss_pulse[p]) begin
                        r_score  <= w_borrow ? '0 : w_sum;
                        r_mult   <= 4'd1;
                        r_streak <= '0;
                    end else if (hit_pulse[p]) begin
                        r_score <= w_carry ? ALL_NINES : w_sum;
                        if (w_streak_inc == STEP) begin
                            r_streak <= '0;
                            if (r_mult < MAX_M) begin
                                r_mult <= r_mult + 4'd1;
                            end
                        end else begin
                            r_streak <= w_streak_inc;
                        end
                    end
                end
            end

            assign score[p*SW +: SW] = r_score;
            assign mult[p*4 +: 4]    = r_mult;
            assign saturated[p]      = (r_score == ALL_NINES);
        end
    endgenerate

    logic [SW-1:0] w_best;
    logic [LW-1:0] w_best_idx;

    // Round leader: strict greater-than keeps ties on the lowest index.
    always_comb begin
        w_best     = '0;
        w_best_idx = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (bcd_gt(bcd_wide_t'(score[i*SW +: SW]), bcd_wide_t'(w_best))) begin
                w_best     = score[i*SW +: SW];
                w_best_idx = LW'(i);
            end
        end
    end

    logic [LW-1:0] r_leader;
    logic [SW-1:0] r_high;
    logic          r_new_high;

    // Tracker registers; high score survives clear and only rst_n resets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_leader   <= '0;
            r_high     <= '0;
            r_new_high <= 1'b0;
        end else begin
            r_leader <= w_best_idx;
            if (bcd_gt(bcd_wide_t'(w_best), bcd_wide_t'(r_high))) begin
                r_high     <= w_best;
                r_new_high <= 1'b1;
            end else begin
                r_new_high <= 1'b0;
            end
        end
    end

    assign leader     = r_leader;
    assign high_score = r_high;
    assign new_high   = r_new_high;

endmodule

// File: tb/tb_score_bank.sv
// tb/tb_score_bank.sv - scoreboard bench for score_bank
module tb_score_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        clear;
    logic [1:0]  hit_pulse;
    logic [1:0]  miss_pulse;
    logic [23:0] score;
    logic [7:0]  mult;
    logic [1:0]  saturated;
    logic [11:0] high_score;
    logic [0:0]  leader;
    logic        new_high;

    score_bank #(
        .NUM_PLAYERS(2), .DIGITS(3), .COMBO_STEP(4), .MAX_MULT(4), .MISS_PENALTY(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .clear      (clear),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .score      (score),
        .mult       (mult),
        .saturated  (saturated),
        .high_score (high_score),
        .leader     (leader),
        .new_high   (new_high)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int s0; int s1; int m0; int m1; } pexp_t;
    typedef struct { int cyc; int ldr; int hs; int nh; } texp_t;

    pexp_t q_p[$];
    texp_t q_t[$];
    int checks   = 0;
    int failures = 0;
    int hs_model = 0;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops expectations once their cycle has been reached.
    initial begin
        forever begin
            @(negedge clk);
            while (q_p.size() > 0 && q_p[0].cyc <= cyc) begin
                pexp_t e;
                e = q_p.pop_front();
                cmp("score_p0", score[11:0], to_bcd(e.s0));
                cmp("score_p1", score[23:12], to_bcd(e.s1));
                cmp("mult_p0", mult[3:0], e.m0);
                cmp("mult_p1", mult[7:4], e.m1);
                cmp("saturated", saturated, {30'd0, e.s1 == 999, e.s0 == 999});
            end
            while (q_t.size() > 0 && q_t[0].cyc <= cyc) begin
                texp_t t;
                t = q_t.pop_front();
                cmp("leader", leader, t.ldr);
                cmp("high_score", high_score, to_bcd(t.hs));
                cmp("new_high", new_high, t.nh);
            end
        end
    end

    // One clocked stimulus cycle with hand-computed post-edge scores/mults.
    task automatic step(input logic [1:0] h, input logic [1:0] m, input logic c,
                        input logic en, input int e0, input int e1,
                        input int em0, input int em1);
        pexp_t pe;
        texp_t te;
        int    mx;
        @(negedge clk);
        hit_pulse  = h;
        miss_pulse = m;
        clear      = c;
        enable     = en;
        pe.cyc = cyc + 1; pe.s0 = e0; pe.s1 = e1; pe.m0 = em0; pe.m1 = em1;
        q_p.push_back(pe);
        te.ldr = (e1 > e0) ? 1 : 0;
        mx     = (e1 > e0) ? e1 : e0;
        if (mx > hs_model) begin
            hs_model = mx;
            te.nh    = 1;
        end else begin
            te.nh    = 0;
        end
        te.cyc = cyc + 2;
        te.hs  = hs_model;
        q_t.push_back(te);
    endtask

    task automatic idle_drain();
        @(negedge clk);
        hit_pulse  = 2'b00;
        miss_pulse = 2'b00;
        clear      = 1'b0;
        for (int i = 0; i < 20 && (q_p.size() + q_t.size()) > 0; i++) begin
            @(negedge clk);
            #1;
        end
        cmp("drain_pending", q_p.size() + q_t.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        cmp({tag, "_score"}, score, 0);
        cmp({tag, "_mult"}, mult, 8'h11);
        cmp({tag, "_sat"}, saturated, 0);
        cmp({tag, "_high"}, high_score, 0);
        cmp({tag, "_leader"}, leader, 0);
        cmp({tag, "_new_high"}, new_high, 0);
    endtask

    int s8[8] = '{1, 2, 3, 4, 6, 8, 10, 12};
    int m8[8] = '{1, 1, 1, 2, 2, 2, 2, 3};
    int s12[12] = '{3, 4, 5, 6, 8, 10, 12, 14, 17, 20, 23, 26};
    int m12[12] = '{1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 4};

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        clear      = 1'b0;
        hit_pulse  = 2'b00;
        miss_pulse = 2'b00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Idle after reset, then four hits raise mult, fifth hit adds 2.
        step(2'b00, 2'b00, 0, 1, 0, 0, 1, 1);
        step(2'b01, 2'b00, 0, 1, 1, 0, 1, 1);
        step(2'b01, 2'b00, 0, 1, 2, 0, 1, 1);
        step(2'b01, 2'b00, 0, 1, 3, 0, 1, 1);
        step(2'b01, 2'b00, 0, 1, 4, 0, 2, 1);
        step(2'b01, 2'b00, 0, 1, 6, 0, 2, 1);
        // Misses: penalty, mult reset, floor at zero.
        step(2'b00, 2'b01, 0, 1, 4, 0, 1, 1);
        step(2'b00, 2'b01, 0, 1, 2, 0, 1, 1);
        step(2'b00, 2'b01, 0, 1, 0, 0, 1, 1);
        step(2'b00, 2'b01, 0, 1, 0, 0, 1, 1);
        // enable low ignores pulses.
        step(2'b11, 2'b00, 0, 0, 0, 0, 1, 1);
        step(2'b00, 2'b11, 0, 0, 0, 0, 1, 1);
        // Same-cycle hit+miss on P0 with hit on P1; streak must restart.
        step(2'b01, 2'b00, 0, 1, 1, 0, 1, 1);
        step(2'b01, 2'b00, 0, 1, 2, 0, 1, 1);
        step(2'b01, 2'b00, 0, 1, 3, 0, 1, 1);
        step(2'b11, 2'b01, 0, 1, 1, 1, 1, 1);
        step(2'b01, 2'b00, 0, 1, 2, 1, 1, 1);
        step(2'b01, 2'b00, 0, 1, 3, 1, 1, 1);
        step(2'b01, 2'b00, 0, 1, 4, 1, 1, 1);
        step(2'b01, 2'b00, 0, 1, 5, 1, 2, 1);
        idle_drain();

        // Climb P0 to 998 with mult 4, then saturate.
        step(2'b00, 2'b00, 1, 1, 0, 0, 1, 1);
        step(2'b01, 2'b00, 0, 1, 1, 0, 1, 1);
        step(2'b01, 2'b00, 0, 1, 2, 0, 1, 1);
        step(2'b01, 2'b00, 0, 1, 3, 0, 1, 1);
        step(2'b00, 2'b01, 0, 1, 1, 0, 1, 1);
        step(2'b01, 2'b00, 0, 1, 2, 0, 1, 1);
        step(2'b01, 2'b00, 0, 1, 3, 0, 1, 1);
        step(2'b01, 2'b00, 0, 1, 4, 0, 1, 1);
        step(2'b00, 2'b01, 0, 1, 2, 0, 1, 1);
        for (int i = 0; i < 12; i++) step(2'b01, 2'b00, 0, 1, s12[i], 0, m12[i], 1);
        for (int i = 1; i <= 243; i++) step(2'b01, 2'b00, 0, 1, 26 + 4 * i, 0, 4, 1);
        step(2'b01, 2'b00, 0, 1, 999, 0, 4, 1);
        step(2'b01, 2'b00, 0, 1, 999, 0, 4, 1);
        step(2'b01, 2'b00, 0, 1, 999, 0, 4, 1);
        idle_drain();

        // Asynchronous reset mid-streak clears everything, high score included.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        hs_model = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Both players to 012 (tie -> leader 0), then P1 to 013.
        for (int i = 0; i < 8; i++) step(2'b11, 2'b00, 0, 1, s8[i], s8[i], m8[i], m8[i]);
        step(2'b00, 2'b11, 0, 1, 10, 10, 1, 1);
        step(2'b11, 2'b00, 0, 1, 11, 11, 1, 1);
        step(2'b11, 2'b00, 0, 1, 12, 12, 1, 1);
        step(2'b10, 2'b00, 0, 1, 12, 13, 1, 1);
        step(2'b00, 2'b00, 0, 1, 12, 13, 1, 1);
        // clear beats a simultaneous hit; high score holds 013.
        step(2'b11, 2'b00, 1, 1, 0, 0, 1, 1);
        step(2'b00, 2'b00, 0, 1, 0, 0, 1, 1);
        idle_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_bank.md
# score_bank

Multi-player BCD score keeper with combo multipliers, miss penalties, saturation and an all-time high-score register. It sits between the hit-detection logic and the seven-segment display driver and generalises the single-channel binary score counter. Each player channel accumulates a decimal score directly in BCD, so the display path needs no binary-to-BCD conversion. A shared tracker reports the current round leader and the all-time high score.

## Interface
- NUM_PLAYERS, 2: number of independent score channels (1..8).
- DIGITS, 3: BCD digits per score; maximum score is 10^DIGITS-1.
- COMBO_STEP, 4: consecutive hits needed to raise the multiplier by one.
- MAX_MULT, 4: multiplier ceiling (1..9).
- MISS_PENALTY, 2: points subtracted on a miss (0..9).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  game running; pulses are ignored while low.
- clear  in  1  new-round clear, synchronous.
- hit_pulse  in  NUM_PLAYERS  one bit per player, single-cycle hit strobe.
- miss_pulse  in  NUM_PLAYERS  one bit per player, single-cycle miss strobe.
- score  out  NUM_PLAYERS*DIGITS*4  per-player BCD score; player p occupies bits [p*DIGITS*4 +: DIGITS*4].
- mult  out  NUM_PLAYERS*4  per-player current multiplier, binary, 1..MAX_MULT.
- saturated  out  NUM_PLAYERS  player score equals the all-9s value.
- high_score  out  DIGITS*4  all-time BCD maximum.
- leader  out  max(1,$clog2(NUM_PLAYERS))  index of the current round leader.
- new_high  out  1  one-cycle pulse when high_score increases.

## Operation
- Reset values:
  - score = 0, mult = 1 and streak = 0 for every player.
  - saturated = 0, high_score = 0, leader = 0, new_high = 0.
- Per-player priority, evaluated each cycle: clear, then !enable (hold all state), then miss, then hit.
  - A hit and a miss on the same player in the same cycle is treated as a miss only.
- Hit:
  - score <= min(score + mult, 10^DIGITS-1), using the multiplier value before this hit.
  - streak <= streak+1. When the new streak equals COMBO_STEP: streak <= 0 and mult <= min(mult+1, MAX_MULT).
  - Hits at saturation still advance streak and mult.
- Miss:
  - score <= max(score - MISS_PENALTY, 0), floored at 0 with no wrap-around.
  - streak <= 0 and mult <= 1.
- Players update independently. Simultaneous events on different players all take effect in the same cycle.
- clear:
  - Sets score to 0, streak to 0 and mult to 1 for all players.
  - high_score is kept; only rst_n clears it.
  - clear overrides pulses arriving in the same cycle.
- saturated is combinational from the score register: high when every digit equals 9.
- Tracker, registered from the score registers:
  - leader = index of the maximum score, with ties going to the lowest index.
  - If the maximum score > high_score, then high_score <= that maximum and new_high <= 1; otherwise new_high <= 0.
- BCD arithmetic:
  - Ripple digit-wise add/subtract of a single-digit operand with decimal correction (+6 / -6 per digit).
  - Carry out of the top digit means saturate. Borrow out of the top digit means floor to 0.
  - The score registers never hold a digit > 9.

## Timing
- Pulse to score/mult/saturated: 1 cycle, updated on the edge that samples the pulse.
- Pulse to leader/high_score/new_high: 2 cycles.
- clear to score = 0: 1 cycle. clear to leader = 0: 2 cycles.
- Back-to-back pulses every cycle are supported, with no pending queue and no lost events.
- Asserting rst_n low mid-game forces all outputs to their reset values immediately.
  - The first edge after release behaves as from reset.

## Structure
- Package score_pkg:
  - bcd_digit_t (4-bit) typedef.
  - BCD_NINE constant.
  - Function bcd_all_nines(DIGITS).
  - Function bcd_gt(a, b) for the leader/high-score compare.
- Sub-module bcd_addsub:
  - Combinational, parametrised by DIGITS.
  - Inputs: value, 4-bit operand, subtract select.
  - Outputs: result, carry_out, borrow_out.
  - Instantiated once per player; the saturate/floor muxing stays in score_bank.

## Test plan
- Reset, then 4 hits on P0 → score 001, 002, 003, 004; mult 1→2 after the 4th hit; 5th hit → 006.
- P0 at 004, miss → 002 and mult 1; second miss → 000; third miss → 000 with no wrap.
- P0 at 998 with mult 4, hit → 999 and saturated=1; further hits keep 999.
- Same cycle: hit+miss on P0 and hit on P1 → P0 drops by 2 (floored at 0) with mult 1; P1 gains its mult.
- P0=012, P1=012 → leader=0; P1 hit → leader=1, high_score=013 and new_high pulses for 1 cycle, both 2 cycles after the pulse.
- clear together with a hit → all scores 000 and mult 1; high_score holds 013.
- rst_n pulse mid-streak → everything returns to its reset value, including high_score=000.
